// File: rtl/reg_bank_fill.sv
// reg_bank_fill: a bank of DEPTH registers, each WIDTH bits wide, with one
// synchronous write port, two combinational read ports and a fill sequencer
// that sweeps a single value into every register, one register per cycle.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   in            write data; also the fill value when fill_req is sampled
//   load          write request for register addr
//   addr          write address
//   rd_addr_a/b   read addresses
//   out_a/b       register contents at rd_addr_a/b
//   fill_req      start a fill sweep with value in
//   busy          high while the fill sweep runs
//   load_rejected one-cycle pulse per dropped load
//
// Optional feature: define REG_BANK_BYPASS_EN to forward a committed write
// to any read port addressing the same register in the same cycle.
module reg_bank_fill #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic [AW-1:0]    addr,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    input  logic             fill_req,
    output logic             busy,
    output logic             load_rejected
);

    typedef enum logic [0:0] {StIdle, StFill} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] fill_val_q, fill_val_d;
    logic             rej_q, rej_d;

    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (fill_req) state_d = StFill;
            StFill: if (cnt_q == AW'(DEPTH - 1)) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs, write-port selection and sequencer datapath next-state
    always_comb begin
        busy       = (state_q == StFill);
        we         = 1'b0;
        waddr      = addr;
        wdata      = in;
        cnt_d      = cnt_q;
        fill_val_d = fill_val_q;
        // Any load seen while filling, or alongside a fill request, is dropped.
        rej_d      = load && (busy || fill_req);
        unique case (state_q)
            StIdle: begin
                if (fill_req) begin
                    fill_val_d = in;
                    cnt_d      = '0;
                end else if (load) begin
                    we = 1'b1;
                end
            end
            StFill: begin
                we    = 1'b1;
                waddr = cnt_q;
                wdata = fill_val_q;
                cnt_d = cnt_q + AW'(1);
            end
            default: ;
        endcase
    end

    // Register bank and sequencer registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            cnt_q      <= '0;
            fill_val_q <= '0;
            rej_q      <= 1'b0;
        end else begin
            if (we) begin
                mem_q[waddr] <= wdata;
            end
            cnt_q      <= cnt_d;
            fill_val_q <= fill_val_d;
            rej_q      <= rej_d;
        end
    end

    assign load_rejected = rej_q;

    // Read ports
    always_comb begin
        out_a = mem_q[rd_addr_a];
        out_b = mem_q[rd_addr_b];
`ifdef REG_BANK_BYPASS_EN
        // A write under reset never commits, so it is not forwarded.
        if (we && rst_n && (waddr == rd_addr_a)) out_a = wdata;
        if (we && rst_n && (waddr == rd_addr_b)) out_b = wdata;
`else
`endif
    end

endmodule

// File: tb/tb_reg_bank_fill.sv
module tb_reg_bank_fill;

    localparam int W  = 16;
    localparam int D  = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  in;
    logic          load;
    logic [AW-1:0] addr;
    logic [AW-1:0] rd_addr_a;
    logic [AW-1:0] rd_addr_b;
    logic [W-1:0]  out_a;
    logic [W-1:0]  out_b;
    logic          fill_req;
    logic          busy;
    logic          load_rejected;

    int n_tests = 0;
    int n_fail  = 0;

    reg_bank_fill #(.WIDTH(W), .DEPTH(D)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in           (in),
        .load         (load),
        .addr         (addr),
        .rd_addr_a    (rd_addr_a),
        .rd_addr_b    (rd_addr_b),
        .out_a        (out_a),
        .out_b        (out_b),
        .fill_req     (fill_req),
        .busy         (busy),
        .load_rejected(load_rejected)
    );

    always #5 clk = ~clk;

    // Behavioural model: bank contents plus how many fill writes remain.
    logic [W-1:0] mem_m [D];
    int           fill_left = 0;
    logic [W-1:0] fill_val_m = '0;
    logic         rej_m = 1'b0;
    bit           model_ok = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < D; i++) mem_m[i] = '0;
            fill_left = 0;
            rej_m     = 1'b0;
            model_ok  = 1'b1;
        end else begin
            rej_m = load && ((fill_left > 0) || fill_req);
            if (fill_left > 0) begin
                mem_m[D - fill_left] = fill_val_m;
                fill_left--;
            end else if (fill_req) begin
                fill_val_m = in;
                fill_left  = D;
            end else if (load) begin
                mem_m[addr] = in;
            end
        end
    end

    function automatic logic [W-1:0] expect_read(input logic [AW-1:0] ra);
        logic [W-1:0] v;
        v = mem_m[ra];
`ifdef REG_BANK_BYPASS_EN
        if (rst_n) begin
            if (fill_left > 0) begin
                if (int'(ra) == D - fill_left) v = fill_val_m;
            end else if (load && !fill_req && ra == addr) begin
                v = in;
            end
        end
`endif
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (model_ok && rst_n) begin
            check("model out_a", 32'(out_a), 32'(expect_read(rd_addr_a)));
            check("model out_b", 32'(out_b), 32'(expect_read(rd_addr_b)));
            check("model busy", 32'(busy), 32'(fill_left > 0));
            check("model load_rejected", 32'(load_rejected), 32'(rej_m));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts busy cycles after a fill request edge; bounded.
    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 40) begin
            n++;
            step();
        end
    endtask

    task automatic check_all(input string name, input logic [W-1:0] exp);
        for (int i = 0; i < D; i++) begin
            rd_addr_a = AW'(i);
            #1;
            check(name, 32'(out_a), 32'(exp));
        end
    endtask

    int n;

    initial begin
        rst_n = 1'b0; in = '0; load = 1'b0; addr = '0;
        rd_addr_a = '0; rd_addr_b = '0; fill_req = 1'b0;
        step();
        step();
        rst_n = 1'b1;

        // Reset then write
        check("reset busy", 32'(busy), 32'h0);
        check("reset load_rejected", 32'(load_rejected), 32'h0);
        load = 1'b1; addr = 3'd3; in = 16'hBEEF;
        step();
        load = 1'b0;
        rd_addr_a = 3'd3;
        #1;
        check("write reg3", 32'(out_a), 32'hBEEF);
        check("write busy", 32'(busy), 32'h0);
        for (int i = 0; i < D; i++) begin
            if (i != 3) begin
                rd_addr_b = AW'(i);
                #1;
                check("other regs zero", 32'(out_b), 32'h0);
            end
        end
        step();

        // Fill sweep
        fill_req = 1'b1; in = 16'h5A5A;
        step();
        fill_req = 1'b0;
        count_busy(n);
        check("fill busy cycles", 32'(n), 32'd8);
        check_all("fill contents", 16'h5A5A);

        // Load during fill cycle 2
        in = 16'h5A5A; fill_req = 1'b1;
        step();
        fill_req = 1'b0;
        step();
        load = 1'b1; addr = 3'd1; in = 16'h1234;
        step();
        load = 1'b0;
        check("rejected pulse", 32'(load_rejected), 32'h1);
        step();
        check("rejected one cycle", 32'(load_rejected), 32'h0);
        count_busy(n);
        rd_addr_a = 3'd1;
        #1;
        check("reg1 after rejected load", 32'(out_a), 32'h5A5A);

        // Simultaneous fill and load in idle
        fill_req = 1'b1; load = 1'b1; addr = 3'd0; in = 16'h0001;
        step();
        fill_req = 1'b0; load = 1'b0;
        check("simul rejected", 32'(load_rejected), 32'h1);
        check("simul busy", 32'(busy), 32'h1);
        step();
        check("simul rejected once", 32'(load_rejected), 32'h0);
        count_busy(n);
        check_all("simul fill contents", 16'h0001);

        // Reset mid-fill
        fill_req = 1'b1; in = 16'h7777;
        step();
        fill_req = 1'b0;
        step();
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midreset busy", 32'(busy), 32'h0);
        check_all("midreset contents", 16'h0000);
        fill_req = 1'b1; in = 16'h3333;
        step();
        fill_req = 1'b0;
        count_busy(n);
        check("refill busy cycles", 32'(n), 32'd8);
        check_all("refill contents", 16'h3333);

        // Read-during-write on port B
        rd_addr_b = 3'd5; load = 1'b1; addr = 3'd5; in = 16'hCAFE;
        #1;
`ifdef REG_BANK_BYPASS_EN
        check("bypass same cycle", 32'(out_b), 32'hCAFE);
`else
        check("no bypass same cycle", 32'(out_b), 32'h3333);
`endif
        step();
        load = 1'b0;
        check("write next cycle", 32'(out_b), 32'hCAFE);
        step();

        // Randomized phase against the model
        for (int c = 0; c < 600; c++) begin
            rst_n     = ($urandom_range(0, 59) != 0);
            fill_req  = ($urandom_range(0, 9) == 0);
            load      = ($urandom_range(0, 2) == 0);
            addr      = AW'($urandom_range(0, D - 1));
            in        = W'($urandom);
            rd_addr_a = AW'($urandom_range(0, D - 1));
            rd_addr_b = ($urandom_range(0, 3) == 0) ? rd_addr_a : AW'($urandom_range(0, D - 1));
            step();
        end
        rst_n = 1'b1; load = 1'b0; fill_req = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
